flags_sequencer: RTL

Control sequencer for the processor-status flags datapath. It accepts one flag-operation request at a time from the instruction decoder over a valid/ready handshake. It drives the one-cycle control strobes (load, clear/set, push, pull) into the flags register, including the multi-cycle BRK/IRQ push-then-set-I sequences. It also tracks the SO pad and schedules the pad-driven V set into free cycles.

---
 rtl/flags_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/flags_sequencer.sv
// Purpose: sequences processor-status flag strobes (incl. BRK/IRQ push-then-set-I) from decoder requests.
// Latency: strobes registered, one cycle after accept; BRK/IRQ span two cycles; pad SO_V 3 cycles after pad fall.
// Backpressure: op_ready is low only in the first BRK/IRQ cycle and depends on state alone.
// Optional SO pad path (synchronizer, edge detect, pending V set) is built when FLAGS_SO_EN is defined.
module flags_sequencer (
  input  logic       PHI0,
  input  logic       RES,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  input  logic       op_ir5,
  input  logic       SO_frompad,
  output logic       done,
  output logic       P_DB,
  output logic       DB_P,
  output logic       DBZ_Z,
  output logic       DB_N,
  output logic       IR5_C,
  output logic       DB_C,
  output logic       ACR_C,
  output logic       IR5_D,
  output logic       IR5_I,
  output logic       DB_V,
  output logic       Z_V,
  output logic       AVR_V,
  output logic       SO_V,
  output logic       B_OUT,
  output logic       BRK6E,
  output logic       IR5
);

  localparam logic [3:0] OP_SETCLR_C = 4'd1;
  localparam logic [3:0] OP_SETCLR_D = 4'd2;
  localparam logic [3:0] OP_SETCLR_I = 4'd3;
  localparam logic [3:0] OP_CLV      = 4'd4;
  localparam logic [3:0] OP_NZ       = 4'd5;
  localparam logic [3:0] OP_ADC      = 4'd6;
  localparam logic [3:0] OP_CMP      = 4'd7;
  localparam logic [3:0] OP_BIT      = 4'd8;
  localparam logic [3:0] OP_PLP      = 4'd9;
  localparam logic [3:0] OP_PHP      = 4'd10;
  localparam logic [3:0] OP_BRK      = 4'd11;
  localparam logic [3:0] OP_IRQ      = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_INT1,
    S_INT2
  } state_t;

  state_t state;
  logic   is_brk;
  logic   accept;

  // The only non-accepting cycle is the push cycle of BRK/IRQ.
  assign op_ready = (state != S_INT1);
  assign accept   = op_valid & op_ready;

  // FSM with registered strobes: every strobe defaults low and is raised for exactly one cycle.
  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      state  <= S_IDLE;
      is_brk <= 1'b0;
      done   <= 1'b0;
      P_DB   <= 1'b0;
      DB_P   <= 1'b0;
      DBZ_Z  <= 1'b0;
      DB_N   <= 1'b0;
      IR5_C  <= 1'b0;
      DB_C   <= 1'b0;
      ACR_C  <= 1'b0;
      IR5_D  <= 1'b0;
      IR5_I  <= 1'b0;
      DB_V   <= 1'b0;
      Z_V    <= 1'b0;
      AVR_V  <= 1'b0;
      B_OUT  <= 1'b0;
      BRK6E  <= 1'b0;
      IR5    <= 1'b0;
    end else begin
      done  <= 1'b0;
      P_DB  <= 1'b0;
      DB_P  <= 1'b0;
      DBZ_Z <= 1'b0;
      DB_N  <= 1'b0;
      IR5_C <= 1'b0;
      DB_C  <= 1'b0;
      ACR_C <= 1'b0;
      IR5_D <= 1'b0;
      IR5_I <= 1'b0;
      DB_V  <= 1'b0;
      Z_V   <= 1'b0;
      AVR_V <= 1'b0;
      B_OUT <= 1'b0;
      BRK6E <= 1'b0;
      IR5   <= 1'b0;
      if (state == S_INT1) begin
        // Second interrupt cycle: set I unconditionally, BRK also flags its final cycle.
        state <= S_INT2;
        IR5_I <= 1'b1;
        IR5   <= 1'b1;
        BRK6E <= is_brk;
        done  <= 1'b1;
      end else if (accept) begin
        if (op_code == OP_BRK || op_code == OP_IRQ) begin
          state  <= S_INT1;
          is_brk <= (op_code == OP_BRK);
          P_DB   <= 1'b1;
          B_OUT  <= (op_code == OP_BRK);
        end else begin
          state <= S_EXEC;
          done  <= 1'b1;
          IR5   <= op_ir5;
          case (op_code)
            OP_SETCLR_C: IR5_C <= 1'b1;
            OP_SETCLR_D: IR5_D <= 1'b1;
            OP_SETCLR_I: IR5_I <= 1'b1;
            OP_CLV:      Z_V   <= 1'b1;
            OP_NZ: begin
              DBZ_Z <= 1'b1;
              DB_N  <= 1'b1;
            end
            OP_ADC: begin
              DBZ_Z <= 1'b1;
              DB_N  <= 1'b1;
              ACR_C <= 1'b1;
              AVR_V <= 1'b1;
            end
            OP_CMP: begin
              DBZ_Z <= 1'b1;
              DB_N  <= 1'b1;
              ACR_C <= 1'b1;
            end
            OP_BIT: begin
              DBZ_Z <= 1'b1;
              DB_N  <= 1'b1;
              DB_V  <= 1'b1;
            end
            OP_PLP: DB_P <= 1'b1;
            OP_PHP: begin
              P_DB  <= 1'b1;
              B_OUT <= 1'b1;
            end
            default: ;
          endcase
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

`ifdef FLAGS_SO_EN
  logic so_s1;
  logic so_s2;
  logic so_s2_d;
  logic so_pend;
  logic so_fall;
  logic op_vsrc;

  // Any op-driven V source takes the cycle; the pad request waits.
  assign op_vsrc = DB_P | DB_V | Z_V | AVR_V;
  assign so_fall = so_s2_d & ~so_s2;
  assign SO_V    = so_pend & ~op_vsrc;

  // Synchronize the pad (idle high), detect falls, and hold a single pending V set.
  always_ff @(posedge PHI0 or posedge RES) begin
    if (RES) begin
      so_s1   <= 1'b1;
      so_s2   <= 1'b1;
      so_s2_d <= 1'b1;
      so_pend <= 1'b0;
    end else begin
      so_s1   <= SO_frompad;
      so_s2   <= so_s1;
      so_s2_d <= so_s2;
      // A fall seen while SO_V fires keeps the request alive for one more SO_V.
      so_pend <= so_fall | (so_pend & ~SO_V);
    end
  end
`else
  logic so_unused;

  assign so_unused = SO_frompad;
  assign SO_V      = 1'b0;
`endif

endmodule
